// File: rtl/midi_stream_parser.sv
// midi_stream_parser: turns a UART MIDI byte stream into channel-voice
// messages that are queued in a small output FIFO. Real-time bytes
// bypass the parser on a separate one-cycle strobe.
// Optional build macro: MIDI_RUNNING_STATUS_EN. When it is defined, the
// status is kept after a completed message (running status). When it is
// undefined, the parser returns to IDLE after every message.

module midi_stream_parser #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] CH_ENABLE  = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] Din,
  input  logic       Din_rdy,
  input  logic       msg_ready,
  output logic       msg_valid,
  output logic [2:0] msg_type,
  output logic [3:0] ch,
  output logic [6:0] D1,
  output logic [6:0] D2,
  output logic       rt_valid,
  output logic [7:0] rt_byte,
  output logic       error
);

  localparam int unsigned AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(FIFO_DEPTH);

  // Message type codes as seen on msg_type.
  localparam logic [2:0] T_NOTE_OFF = 3'd0;
  localparam logic [2:0] T_NOTE_ON  = 3'd1;
  localparam logic [2:0] T_PROG     = 3'd4;
  localparam logic [2:0] T_CH_AT    = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_D1,
    ST_WAIT_D2,
    ST_SYSEX
  } state_t;

`ifdef MIDI_RUNNING_STATUS_EN
  localparam state_t LP_AFTER_MSG = ST_WAIT_D1;
`else
  localparam state_t LP_AFTER_MSG = ST_IDLE;
`endif

  // Parser state and latched status
  state_t     r_state, w_state_nxt;
  logic [2:0] r_type,  w_type_nxt;
  logic [3:0] r_ch,    w_ch_nxt;
  logic [6:0] r_d1,    w_d1_nxt;
  // Set while a status byte is latched but no message has completed
  // under it yet; distinguishes a fresh WAIT_D1 (incomplete message)
  // from a running-status WAIT_D1 (nothing outstanding).
  logic       r_fresh, w_fresh_nxt;

  // Per-byte decode results
  logic       w_is_rt;
  logic       w_done;
  logic       w_fsm_err;
  logic [2:0] w_msg_type;
  logic [6:0] w_msg_d1;
  logic [6:0] w_msg_d2;

  // Completed-message staging register (one cycle before the FIFO write)
  logic        r_push;
  logic [20:0] r_push_word;

  // Real-time and error outputs
  logic       r_rt_valid;
  logic [7:0] r_rt_byte;
  logic       r_error;

  // Output FIFO
  logic [20:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          w_ovf;
  logic [20:0]   w_head;

  assign w_is_rt = Din_rdy & (Din[7:3] == 5'b11111);

  // Next-state, latch updates and message completion for each strobed byte
  always_comb begin
    w_state_nxt = r_state;
    w_type_nxt  = r_type;
    w_ch_nxt    = r_ch;
    w_d1_nxt    = r_d1;
    w_fresh_nxt = r_fresh;
    w_done      = 1'b0;
    w_fsm_err   = 1'b0;
    w_msg_d1    = r_d1;
    w_msg_d2    = '0;
    if (Din_rdy && !w_is_rt) begin
      if (Din[7:4] == 4'hF) begin
        // System common / exclusive: running status is lost
        w_fresh_nxt = 1'b0;
        w_state_nxt = (Din[3:0] == 4'h0) ? ST_SYSEX : ST_IDLE;
      end else if (Din[7]) begin
        // Channel status byte: abandoning a half-received message is an error
        if ((r_state == ST_WAIT_D2) || ((r_state == ST_WAIT_D1) && r_fresh)) begin
          w_fsm_err = 1'b1;
        end
        w_type_nxt  = Din[6:4];
        w_ch_nxt    = Din[3:0];
        w_fresh_nxt = 1'b1;
        w_state_nxt = ST_WAIT_D1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            w_fsm_err = 1'b1;
          end
          ST_WAIT_D1: begin
            w_d1_nxt = Din[6:0];
            w_msg_d1 = Din[6:0];
            if ((r_type == T_PROG) || (r_type == T_CH_AT)) begin
              w_done      = 1'b1;
              w_fresh_nxt = 1'b0;
              w_state_nxt = LP_AFTER_MSG;
            end else begin
              w_state_nxt = ST_WAIT_D2;
            end
          end
          ST_WAIT_D2: begin
            w_msg_d2    = Din[6:0];
            w_done      = 1'b1;
            w_fresh_nxt = 1'b0;
            w_state_nxt = LP_AFTER_MSG;
          end
          ST_SYSEX: begin
            w_state_nxt = ST_SYSEX;
          end
          default: begin
            w_state_nxt = ST_IDLE;
          end
        endcase
      end
    end
  end

  // A NOTE_ON with zero velocity is reported as NOTE_OFF
  always_comb begin
    w_msg_type = r_type;
    if ((r_type == T_NOTE_ON) && (w_msg_d2 == '0)) begin
      w_msg_type = T_NOTE_OFF;
    end
  end

  // Parser state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_type  <= '0;
      r_ch    <= '0;
      r_d1    <= '0;
      r_fresh <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_type  <= w_type_nxt;
      r_ch    <= w_ch_nxt;
      r_d1    <= w_d1_nxt;
      r_fresh <= w_fresh_nxt;
    end
  end

  // Stage completed messages, real-time strobe and error pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_push      <= 1'b0;
      r_push_word <= '0;
      r_rt_valid  <= 1'b0;
      r_rt_byte   <= '0;
      r_error     <= 1'b0;
    end else begin
      r_push      <= w_done & CH_ENABLE[r_ch];
      r_push_word <= {w_msg_type, r_ch, w_msg_d1, w_msg_d2};
      r_rt_valid  <= w_is_rt;
      r_rt_byte   <= w_is_rt ? Din : '0;
      r_error     <= w_fsm_err | w_ovf;
    end
  end

  assign msg_valid = (r_count != '0);
  assign w_full    = (r_count == LP_DEPTH);
  assign w_pop     = msg_valid & msg_ready;
  // When full, a same-cycle pop frees the slot the push needs
  assign w_wr      = r_push & (~w_full | w_pop);
  assign w_ovf     = r_push & w_full & ~w_pop;

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= r_push_word;
    end
  end

  assign w_head = msg_valid ? r_mem[r_rd_ptr] : '0;
  assign {msg_type, ch, D1, D2} = w_head;

  assign rt_valid = r_rt_valid;
  assign rt_byte  = r_rt_byte;
  assign error    = r_error;

endmodule

// File: tb/tb_midi_stream_parser.sv
// Testbench for midi_stream_parser: directed scenarios plus a randomized
// byte stream checked against a message-level reference model.

module tb_midi_stream_parser;

  localparam int unsigned DEPTH = 4;
  localparam logic [15:0] MASK  = 16'hFFFD;  // channel 1 disabled
`ifdef MIDI_RUNNING_STATUS_EN
  localparam bit RS = 1'b1;
`else
  localparam bit RS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] Din = '0;
  logic       Din_rdy = 1'b0;
  logic       msg_ready = 1'b1;
  logic       msg_valid;
  logic [2:0] msg_type;
  logic [3:0] ch;
  logic [6:0] D1;
  logic [6:0] D2;
  logic       rt_valid;
  logic [7:0] rt_byte;
  logic       error;

  midi_stream_parser #(.FIFO_DEPTH(DEPTH), .CH_ENABLE(MASK)) dut (
    .clk(clk), .rst_n(rst_n), .Din(Din), .Din_rdy(Din_rdy),
    .msg_ready(msg_ready), .msg_valid(msg_valid), .msg_type(msg_type),
    .ch(ch), .D1(D1), .D2(D2), .rt_valid(rt_valid), .rt_byte(rt_byte),
    .error(error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Entries as {type[2:0], ch[3:0], d1[6:0], d2[6:0]}
  logic [20:0] got[$];
  logic [20:0] expq[$];

  // Record every dequeued entry
  always @(negedge clk) begin
    if (rst_n && msg_valid && msg_ready) got.push_back({msg_type, ch, D1, D2});
  end

  function automatic logic [20:0] ent(input int t, input int c, input int d1, input int d2);
    return {t[2:0], c[3:0], d1[6:0], d2[6:0]};
  endfunction

  // Reference model state: message-level view of the stream
  logic [7:0] m_status;   // 0 = no status in force
  bit         m_sysex;
  logic [7:0] m_data[$];
  bit         m_owed;     // a status/partial message is outstanding

  task automatic model_reset();
    m_status = '0; m_sysex = 1'b0; m_data.delete(); m_owed = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b, output bit e, output bit rv);
    int need, t, c, d2;
    e = 1'b0; rv = 1'b0;
    if (b >= 8'hF8) rv = 1'b1;
    else if (b == 8'hF0) begin m_sysex = 1'b1; m_status = '0; m_data.delete(); m_owed = 1'b0; end
    else if (b >= 8'hF1) begin m_sysex = 1'b0; m_status = '0; m_data.delete(); m_owed = 1'b0; end
    else if (b >= 8'h80) begin
      e = m_owed;
      m_status = b; m_sysex = 1'b0; m_data.delete(); m_owed = 1'b1;
    end else if (m_sysex) begin
      e = 1'b0;
    end else if (m_status == 8'h00) begin
      e = 1'b1;
    end else begin
      need = (m_status >= 8'hC0 && m_status < 8'hE0) ? 1 : 2;
      m_data.push_back(b);
      if (m_data.size() == need) begin
        t  = int'(m_status[6:4]);
        c  = int'(m_status[3:0]);
        d2 = (need == 2) ? int'(m_data[1]) : 0;
        if (t == 1 && d2 == 0) t = 0;
        if (MASK[c]) expq.push_back(ent(t, c, int'(m_data[0]), d2));
        m_data.delete();
        m_owed = 1'b0;
        if (!RS) m_status = '0;
      end else begin
        m_owed = 1'b1;
      end
    end
  endtask

  // Strobe one byte; sample registered outputs just after the capturing edge
  task automatic send(input logic [7:0] b, output logic e, output logic rv, output logic [7:0] rb);
    @(negedge clk);
    Din = b; Din_rdy = 1'b1;
    @(posedge clk); #1;
    e = error; rv = rt_valid; rb = rt_byte;
    Din_rdy = 1'b0; Din = '0;
  endtask

  // Let the FIFO empty with msg_ready high; to=1 if it never empties
  task automatic drain(output bit to);
    to = 1'b1;
    msg_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 40; i++) begin
      if (!msg_valid) begin to = 1'b0; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; msg_ready = 1'b1;
    Din = 8'hF8; Din_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({msg_valid, msg_type, ch, D1, D2} !== '0)
      begin fails++; $display("FAIL reset_msg: got %h expected 0", {msg_valid, msg_type, ch, D1, D2}); end
    tests++;
    if ({rt_valid, rt_byte, error} !== '0)
      begin fails++; $display("FAIL reset_aux: got %h expected 0", {rt_valid, rt_byte, error}); end
    Din_rdy = 1'b0; Din = '0; rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    tests++;
    if ({msg_valid, rt_valid, error} !== 3'b000)
      begin fails++; $display("FAIL reset_release: got %b expected 000", {msg_valid, rt_valid, error}); end
  endtask

  task automatic test_note_on();
    logic [7:0] seq[$]; logic e, rv; logic [7:0] rb; bit to;
    seq = '{8'h90, 8'h3C, 8'h64};
    msg_ready = 1'b0;
    foreach (seq[i]) begin
      send(seq[i], e, rv, rb);
      tests++;
      if (e !== 1'b0) begin fails++; $display("FAIL note_on_err byte %0d: error=%b expected 0", i, e); end
    end
    tests++;
    if (msg_valid !== 1'b0) begin fails++; $display("FAIL note_on_early: msg_valid=%b expected 0", msg_valid); end
    @(posedge clk); #1;
    tests++;
    if (msg_valid !== 1'b1) begin fails++; $display("FAIL note_on_latency: msg_valid=%b expected 1", msg_valid); end
    tests++;
    if ({msg_type, ch, D1, D2} !== ent(1, 0, 'h3C, 'h64))
      begin fails++; $display("FAIL note_on_head: got %h expected %h", {msg_type, ch, D1, D2}, ent(1, 0, 'h3C, 'h64)); end
    expq.push_back(ent(1, 0, 'h3C, 'h64));
    drain(to);
    tests++;
    if (to) begin fails++; $display("FAIL note_on_drain: timeout=1 expected 0"); end
    tests++;
    if (got.size() != expq.size()) begin fails++; $display("FAIL note_on_count: got %0d expected %0d", got.size(), expq.size()); end
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      tests++;
      if (got[i] !== expq[i]) begin fails++; $display("FAIL note_on_entry %0d: got %h expected %h", i, got[i], expq[i]); end
    end
    got.delete(); expq.delete();
  endtask

  task automatic test_running_status();
    logic [7:0] seq[$]; bit ee[$]; logic e, rv; logic [7:0] rb; bit to;
    seq = '{8'h93, 8'h40, 8'h7F, 8'h41, 8'h00};
    expq.push_back(ent(1, 3, 'h40, 'h7F));
    if (RS) begin
      ee = '{0, 0, 0, 0, 0};
      expq.push_back(ent(0, 3, 'h41, 'h00));
    end else begin
      ee = '{0, 0, 0, 1, 1};
    end
    foreach (seq[i]) begin
      send(seq[i], e, rv, rb);
      tests++;
      if (e !== ee[i]) begin fails++; $display("FAIL running_err byte %0d (%h): error=%b expected %b", i, seq[i], e, ee[i]); end
    end
    drain(to);
    tests++;
    if (to) begin fails++; $display("FAIL running_drain: timeout=1 expected 0"); end
    tests++;
    if (got.size() != expq.size()) begin fails++; $display("FAIL running_count: got %0d expected %0d", got.size(), expq.size()); end
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      tests++;
      if (got[i] !== expq[i]) begin fails++; $display("FAIL running_entry %0d: got %h expected %h", i, got[i], expq[i]); end
    end
    got.delete(); expq.delete();
  endtask

  task automatic test_realtime();
    logic [7:0] seq[$]; logic e, rv; logic [7:0] rb; bit to;
    seq = '{8'hC5, 8'h0A, 8'hB0, 8'h07, 8'hF8, 8'h64, 8'h95, 8'h30, 8'h00};
    foreach (seq[i]) begin
      send(seq[i], e, rv, rb);
      tests++;
      if (e !== 1'b0) begin fails++; $display("FAIL rt_err byte %0d: error=%b expected 0", i, e); end
      tests++;
      if (rv !== (seq[i] == 8'hF8)) begin fails++; $display("FAIL rt_valid byte %0d: got %b expected %b", i, rv, seq[i] == 8'hF8); end
      if (seq[i] == 8'hF8) begin
        tests++;
        if (rb !== 8'hF8) begin fails++; $display("FAIL rt_byte: got %h expected f8", rb); end
      end
    end
    expq.push_back(ent(4, 5, 'h0A, 0));
    expq.push_back(ent(3, 0, 'h07, 'h64));
    expq.push_back(ent(0, 5, 'h30, 0));
    drain(to);
    tests++;
    if (to) begin fails++; $display("FAIL rt_drain: timeout=1 expected 0"); end
    tests++;
    if (got.size() != expq.size()) begin fails++; $display("FAIL rt_count: got %0d expected %0d", got.size(), expq.size()); end
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      tests++;
      if (got[i] !== expq[i]) begin fails++; $display("FAIL rt_entry %0d: got %h expected %h", i, got[i], expq[i]); end
    end
    got.delete(); expq.delete();
  endtask

  task automatic test_sysex();
    logic [7:0] seq[$]; logic e, rv; logic [7:0] rb; bit to;
    seq = '{8'hF0, 8'h12, 8'h34, 8'hF7, 8'h05, 8'h90, 8'h3C, 8'h80, 8'h3C, 8'h40,
            8'hF0, 8'h11, 8'h93, 8'h40, 8'h7F};
    foreach (seq[i]) begin
      send(seq[i], e, rv, rb);
      tests++;
      if (e !== (i == 4 || i == 7)) begin fails++; $display("FAIL sysex_err byte %0d (%h): error=%b expected %b", i, seq[i], e, (i == 4 || i == 7)); end
    end
    expq.push_back(ent(0, 0, 'h3C, 'h40));
    expq.push_back(ent(1, 3, 'h40, 'h7F));
    drain(to);
    tests++;
    if (to) begin fails++; $display("FAIL sysex_drain: timeout=1 expected 0"); end
    tests++;
    if (got.size() != expq.size()) begin fails++; $display("FAIL sysex_count: got %0d expected %0d", got.size(), expq.size()); end
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      tests++;
      if (got[i] !== expq[i]) begin fails++; $display("FAIL sysex_entry %0d: got %h expected %h", i, got[i], expq[i]); end
    end
    got.delete(); expq.delete();
  endtask

  task automatic test_fifo_full();
    logic e, rv; logic [7:0] rb; bit to;
    logic [7:0] chs[$]; logic [7:0] sb, b1, b2;
    chs = '{8'd0, 8'd2, 8'd3, 8'd4, 8'd5};
    msg_ready = 1'b0;
    foreach (chs[k]) begin
      sb = 8'h90 | chs[k]; b1 = 8'h10 + 8'(k); b2 = 8'h20 + 8'(k);
      send(sb, e, rv, rb);
      tests++; if (e !== 1'b0) begin fails++; $display("FAIL full_err msg %0d status: error=%b expected 0", k, e); end
      send(b1, e, rv, rb);
      tests++; if (e !== 1'b0) begin fails++; $display("FAIL full_err msg %0d d1: error=%b expected 0", k, e); end
      send(b2, e, rv, rb);
      tests++; if (e !== 1'b0) begin fails++; $display("FAIL full_err msg %0d d2: error=%b expected 0", k, e); end
      if (k < 4) expq.push_back(ent(1, int'(chs[k]), int'(b1), int'(b2)));
    end
    @(posedge clk); #1;
    tests++;
    if (error !== 1'b1) begin fails++; $display("FAIL full_overflow: error=%b expected 1", error); end
    @(posedge clk); #1;
    tests++;
    if (error !== 1'b0 || msg_valid !== 1'b1) begin fails++; $display("FAIL full_after: error=%b valid=%b expected 0 1", error, msg_valid); end
    // Push into a full FIFO while the head is popped in the same cycle
    send(8'hA6, e, rv, rb);
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL full_pp status: error=%b expected 0", e); end
    send(8'h11, e, rv, rb);
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL full_pp d1: error=%b expected 0", e); end
    send(8'h22, e, rv, rb);
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL full_pp d2: error=%b expected 0", e); end
    msg_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (error !== 1'b0) begin fails++; $display("FAIL full_push_pop: error=%b expected 0", error); end
    expq.push_back(ent(2, 6, 'h11, 'h22));
    drain(to);
    tests++;
    if (to) begin fails++; $display("FAIL full_drain: timeout=1 expected 0"); end
    tests++;
    if (got.size() != expq.size()) begin fails++; $display("FAIL full_count: got %0d expected %0d", got.size(), expq.size()); end
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      tests++;
      if (got[i] !== expq[i]) begin fails++; $display("FAIL full_entry %0d: got %h expected %h", i, got[i], expq[i]); end
    end
    got.delete(); expq.delete();
  endtask

  task automatic test_ch_enable();
    logic [7:0] seq[$]; logic e, rv; logic [7:0] rb; bit to;
    seq = '{8'h91, 8'h3C, 8'h64, 8'h92, 8'h3C, 8'h64};
    foreach (seq[i]) begin
      send(seq[i], e, rv, rb);
      tests++;
      if (e !== 1'b0) begin fails++; $display("FAIL chen_err byte %0d: error=%b expected 0", i, e); end
    end
    expq.push_back(ent(1, 2, 'h3C, 'h64));
    drain(to);
    tests++;
    if (to) begin fails++; $display("FAIL chen_drain: timeout=1 expected 0"); end
    tests++;
    if (got.size() != expq.size()) begin fails++; $display("FAIL chen_count: got %0d expected %0d", got.size(), expq.size()); end
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      tests++;
      if (got[i] !== expq[i]) begin fails++; $display("FAIL chen_entry %0d: got %h expected %h", i, got[i], expq[i]); end
    end
    got.delete(); expq.delete();
  endtask

  task automatic test_reset_mid();
    logic e, rv; logic [7:0] rb; bit to;
    msg_ready = 1'b0;
    send(8'h90, e, rv, rb); send(8'h3C, e, rv, rb); send(8'h64, e, rv, rb);
    send(8'h90, e, rv, rb); send(8'h3C, e, rv, rb);
    rst_n = 1'b0; Din = 8'h64; Din_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({msg_valid, error, rt_valid} !== 3'b000) begin fails++; $display("FAIL midreset_outs: got %b expected 000", {msg_valid, error, rt_valid}); end
    rst_n = 1'b1; Din_rdy = 1'b0; Din = '0;
    msg_ready = 1'b1;
    send(8'h64, e, rv, rb);
    tests++;
    if (e !== 1'b1) begin fails++; $display("FAIL midreset_err: error=%b expected 1", e); end
    drain(to);
    tests++;
    if (to) begin fails++; $display("FAIL midreset_drain: timeout=1 expected 0"); end
    tests++;
    if (got.size() != 0) begin fails++; $display("FAIL midreset_count: got %0d expected 0", got.size()); end
    got.delete(); expq.delete();
  endtask

  task automatic test_random();
    logic e, rv; logic [7:0] rb, b; bit ee, erv; bit to; int r;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; msg_ready = 1'b1;
    model_reset();
    got.delete(); expq.delete();
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 47)      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 127));
      else if (r < 77) b = 8'($urandom_range(8'h80, 8'hEF));
      else if (r < 85) b = 8'($urandom_range(8'hF8, 8'hFF));
      else if (r < 90) b = 8'hF0;
      else if (r < 94) b = 8'hF7;
      else             b = 8'($urandom_range(8'hF1, 8'hF6));
      model_byte(b, ee, erv);
      send(b, e, rv, rb);
      tests++;
      if ({e, rv} !== {ee, erv} || (erv && rb !== b)) begin
        fails++;
        $display("FAIL rand_byte %0d (%h): error=%b rt_valid=%b rt_byte=%h expected %b %b %h", n, b, e, rv, rb, ee, erv, b);
      end
    end
    drain(to);
    tests++;
    if (to) begin fails++; $display("FAIL rand_drain: timeout=1 expected 0"); end
    tests++;
    if (got.size() != expq.size()) begin fails++; $display("FAIL rand_count: got %0d expected %0d", got.size(), expq.size()); end
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      tests++;
      if (got[i] !== expq[i]) begin fails++; $display("FAIL rand_entry %0d: got %h expected %h", i, got[i], expq[i]); end
    end
    got.delete(); expq.delete();
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_running_status();
    test_realtime();
    test_sysex();
    test_fifo_full();
    test_ch_enable();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/midi_stream_parser.md
MIDI_STREAM_PARSER -- requirements
Module: midi_stream_parser

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output message FIFO depth (power of two, 2..16).
REQ-002 SHALL have parameter CH_ENABLE, default 16'hFFFF, per-channel accept mask (bit n = channel n).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port Din  input  8  MIDI byte from UART.
REQ-006 SHALL have port Din_rdy  input  1  Din valid this cycle (one-cycle strobe per byte).
REQ-007 SHALL have port msg_ready  input  1  consumer accepts FIFO head this cycle.
REQ-008 SHALL have port msg_valid  output  1  FIFO non-empty; head fields valid.
REQ-009 SHALL have port msg_type  output  3  0 NOTE_OFF, 1 NOTE_ON, 2 POLY_AT, 3 CTRL, 4 PROG, 5 CH_AT, 6 PITCH.
REQ-010 SHALL have ports ch  output  4, D1  output  7, D2  output  7  head channel, data byte 1, data byte 2 (D2=0 for 1-byte types).
REQ-011 SHALL have ports rt_valid  output  1, rt_byte  output  8  real-time byte strobe and value.
REQ-012 SHALL have port error  output  1  one-cycle error pulse.

Function
REQ-013 FSM states: IDLE (no running status), WAIT_D1, WAIT_D2, SYSEX; transitions only on Din_rdy=1.
REQ-014 Status 8n..En: latch type/channel, go WAIT_D1; from WAIT_D1/WAIT_D2 with message incomplete, pulse error and restart with new status.
REQ-015 Data byte (bit7=0) in WAIT_D1: latch D1; Cn/Dn complete message, others go WAIT_D2.
REQ-016 Data byte in WAIT_D2: latch D2, complete message, return to WAIT_D1 (running status retained).
REQ-017 Data byte in IDLE: pulse error, discard byte, stay IDLE; data byte in SYSEX: discard silently.
REQ-018 F0 enters SYSEX; F7 or any status F1..F7 from any state clears running status, go IDLE; 8n..En in SYSEX exits SYSEX as REQ-014 (no error).
REQ-019 Real-time F8..FF: rt_valid=1, rt_byte=Din the following cycle for one cycle; FSM state, latched data untouched.
REQ-020 NOTE_ON with D2=0 SHALL be pushed as msg_type 0 (NOTE_OFF), D2=0.
REQ-021 Completed message with CH_ENABLE[ch]=0 SHALL be dropped without error.
REQ-022 Completed message pushed to FIFO in the cycle after the final byte's Din_rdy; msg_valid rises one cycle after that when FIFO was empty.
REQ-023 Head dequeued when msg_valid and msg_ready both 1; FIFO order preserved; pointers wrap modulo FIFO_DEPTH.
REQ-024 Push when full and no same-cycle pop: message dropped, error pulsed, contents unchanged; push and pop same cycle when full both succeed.
REQ-025 msg_ready with FIFO empty SHALL have no effect.

Reset
REQ-026 rst_n=0 at a clock edge: FSM IDLE, FIFO empty, running status cleared, all outputs 0 next cycle.
REQ-027 Reset mid-message SHALL discard the partial message; bytes during reset ignored.

Configuration
REQ-028 Macro MIDI_RUNNING_STATUS_EN defined: REQ-016 running status as stated.
REQ-029 Macro undefined: after a completed message FSM returns to IDLE; next data byte without status pulses error (REQ-017).

Verification
REQ-030 Bytes 90,3C,64 -> one entry type 1, ch 0, D1 3C, D2 64; msg_valid 2 cycles after the 64 strobe.
REQ-031 Bytes 93,40,7F,41,00 (macro defined) -> entries {1,3,40,7F} then {0,3,41,00}; macro undefined -> first entry, error on 41, 00 discarded.
REQ-032 Bytes C5,0A then B0,07 F8 64 -> {4,5,0A,00}, rt_valid with rt_byte F8 between, then {3,0,07,64}, no error.
REQ-033 Bytes F0,12,34,F7,05 -> no entries, error only on 05; bytes 90,3C,80 -> error on 80, state WAIT_D1 ch 0.
REQ-034 msg_ready=0, five NOTE_ON messages, FIFO_DEPTH 4 -> 4 entries kept, error on fifth; drain yields original order.
REQ-035 CH_ENABLE=16'h0001, bytes 91,3C,64 -> no entry, no error; rst_n low after 90,3C then 64 -> no entry, error on 64.
